// File: rtl/dcache_direct_mapped_if.sv
// CPU byte port and memory block port of the direct-mapped data cache.
// master = CPU plus data_memory side, slave = the cache itself.
interface dcache_direct_mapped_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back/write-allocate data cache: hits in 0 stall cycles, misses hold BUSYWAIT
// through optional write-back then fetch. DCACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT.
module dcache_direct_mapped #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 3
) (
  input  logic CLK,
  input  logic RESET_N,
  dcache_direct_mapped_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int NUM_BLOCKS = 2 ** INDEX_BITS;

  if (TAG_BITS != 6 - INDEX_BITS) begin : g_bad_params
    $error("dcache_direct_mapped: TAG_BITS must equal 6 - INDEX_BITS");
  end

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    FETCH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]         data_arr [NUM_BLOCKS];
  logic [TAG_BITS-1:0] tag_arr  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [1:0]            off;
  logic                  req;
  logic                  wr_req;
  logic                  rd_req;
  logic                  hit;
  logic [7:0]            sel_byte;
  logic                  rd_hit;
  logic                  wr_hit;
  logic                  miss_fire;
  logic                  fill_done;
  logic [7:0]            readdata_q;

  logic                  busy;
  logic                  mem_read;
  logic                  mem_write;
  logic [5:0]            mem_address;
  logic [31:0]           mem_writedata;

  assign off     = bus.ADDRESS[1:0];
  assign idx     = bus.ADDRESS[2 +: INDEX_BITS];
  assign req_tag = bus.ADDRESS[7 -: TAG_BITS];

  // WRITE wins if the CPU ever raises both strobes.
  assign req    = bus.READ | bus.WRITE;
  assign wr_req = bus.WRITE;
  assign rd_req = bus.READ & ~bus.WRITE;

  assign hit      = valid[idx] && (tag_arr[idx] == req_tag);
  assign sel_byte = data_arr[idx][{off, 3'b000} +: 8];

  assign rd_hit    = (state == IDLE) && rd_req && hit;
  assign wr_hit    = (state == IDLE) && wr_req && hit;
  assign miss_fire = (state == IDLE) && req && !hit;
  assign fill_done = (state == FETCH) && !bus.MEM_BUSYWAIT;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          busy      = 1'b1;
          state_nxt = dirty[idx] ? WRITE_BACK : FETCH;
        end
      end
      WRITE_BACK: begin
        busy          = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {tag_arr[idx], idx};
        mem_writedata = data_arr[idx];
        if (!bus.MEM_BUSYWAIT) state_nxt = FETCH;
      end
      FETCH: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_address = {req_tag, idx};
        if (!bus.MEM_BUSYWAIT) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The miss stall is combinational from the CPU inputs, so reset must mask it directly.
  assign bus.BUSYWAIT      = RESET_N & busy;
  assign bus.MEM_READ      = mem_read;
  assign bus.MEM_WRITE     = mem_write;
  assign bus.MEM_ADDRESS   = mem_address;
  assign bus.MEM_WRITEDATA = mem_writedata;
  assign bus.READDATA      = rd_hit ? sel_byte : readdata_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid      <= '0;
      dirty      <= '0;
      readdata_q <= '0;
    end else begin
      if (fill_done) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty[idx] <= 1'b1;
      end
      if (rd_hit) readdata_q <= sel_byte;
    end
  end

  // Data and tags survive reset; only the valid bits make them meaningful.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      data_arr[idx] <= bus.MEM_READDATA;
      tag_arr[idx]  <= req_tag;
    end else if (wr_hit) begin
      data_arr[idx][{off, 3'b000} +: 8] <= bus.WRITEDATA;
    end
  end

`ifdef DCACHE_STATS_EN
  logic after_fill_q;
  logic hit_event;

  // The cycle right after a fill is the completion of that miss, not a fresh hit.
  assign hit_event = (state == IDLE) && req && hit && !after_fill_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      after_fill_q <= 1'b0;
      HIT_COUNT    <= '0;
      MISS_COUNT   <= '0;
    end else begin
      after_fill_q <= fill_done;
      if (hit_event && (HIT_COUNT != 16'hFFFF))  HIT_COUNT  <= HIT_COUNT + 16'd1;
      if (miss_fire && (MISS_COUNT != 16'hFFFF)) MISS_COUNT <= MISS_COUNT + 16'd1;
    end
  end
`endif

  a_mem_excl: assert property (@(posedge CLK) disable iff (!RESET_N) !(mem_read && mem_write));
  a_cpu_stable: assert property (@(posedge CLK) disable iff (!RESET_N)
    (state != IDLE) |-> ($stable(bus.ADDRESS) && $stable(bus.READ) && $stable(bus.WRITE)));

endmodule
